// File: rtl/mp_add_sequencer_if.sv
// Bundle of the request/result handshake and the external n-bit adder port
// used by mp_add_sequencer. The slave modport is the sequencer's view.
interface mp_add_sequencer_if #(
  parameter int n     = 128,
  parameter int words = 4
);
  logic                 start;
  logic                 abort;
  logic                 cin;
  logic [n*words-1:0]   a;
  logic [n*words-1:0]   b;
  logic                 ready;
  logic                 done;
  logic [n*words-1:0]   s;
  logic                 cout;
  logic                 ovf;
  logic [n-1:0]         add_a;
  logic [n-1:0]         add_b;
  logic                 add_cin;
  logic [n-1:0]         add_s;
  logic                 add_cout;

  modport slave (
    input  start, abort, cin, a, b, add_s, add_cout,
    output ready, done, s, cout, ovf, add_a, add_b, add_cin
  );

  modport master (
    output start, abort, cin, a, b, add_s, add_cout,
    input  ready, done, s, cout, ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder: streams n*words-bit operands LSW-first through one
// shared external n-bit adder. Define MP_ADD_SEQUENCER_OVF_EN to register signed overflow.
module mp_add_sequencer #(
  parameter int n     = 128,
  parameter int words = 4
) (
  input logic                clk,
  input logic                rst_n,
  mp_add_sequencer_if.slave  bus
);

  localparam int W  = n * words;
  localparam int CW = (words > 2) ? $clog2(words) : 1;
  localparam logic [CW-1:0] LAST = CW'(words - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          last_word;

  assign last_word = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cin_d   = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort wins even on the last word, so cout/ovf keep the previous result
        if (bus.abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          s_d[cnt_q*n +: n] = bus.add_s;
          carry_d           = bus.add_cout;
          cnt_d             = cnt_q + 1'b1;
          if (last_word) begin
            cout_d  = bus.add_cout;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  // Captured operands are only meaningful after an accepted start, so no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
  end

`ifdef MP_ADD_SEQUENCER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && !bus.abort && last_word)
      ovf_d = (a_q[W-1] == b_q[W-1]) && (bus.add_s[n-1] != a_q[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.s       = s_q;
  assign bus.cout    = cout_q;
  assign bus.add_a   = (state_q == RUN) ? a_q[cnt_q*n +: n] : '0;
  assign bus.add_b   = (state_q == RUN) ? b_q[cnt_q*n +: n] : '0;
  assign bus.add_cin = (state_q == RUN) ? ((cnt_q == '0) ? cin_q : carry_q) : 1'b0;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer with n=8, words=4 and an ideal external adder.
module tb_mp_add_sequencer;

  localparam int N = 8;
  localparam int WORDS = 4;
`ifdef MP_ADD_SEQUENCER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mp_add_sequencer_if #(.n(N), .words(WORDS)) bus ();

  mp_add_sequencer #(.n(N), .words(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  int errors = 0;
  int checks = 0;

  logic       cin_log  [1:10];
  logic       rdy_log  [1:10];
  logic [7:0] adda_log [1:10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one start, then observe 10 cycles; cycle 1 is RUN word 0.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int st1, input int st2, input int ab,
                        output int dcyc, output int pulses);
    dcyc = 0;
    pulses = 0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1; bus.abort = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (dcyc == 0) dcyc = c;
      end
      cin_log[c]  = bus.add_cin;
      rdy_log[c]  = bus.ready;
      adda_log[c] = bus.add_a;
      bus.start = (c == st1) || (c == st2);
      bus.abort = (c == ab);
      if (c == st1) bus.a = ~a;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int dcyc, input int pulses);
    chk({tag, ".s"}, {32'd0, bus.s}, {32'd0, v.s});
    chk({tag, ".cout"}, {63'd0, bus.cout}, {63'd0, v.cout});
    chk({tag, ".ovf"}, {63'd0, bus.ovf}, {63'd0, v.ovf & OVF_EN});
    chk({tag, ".done_cycle"}, 64'(dcyc), 64'd5);
    chk({tag, ".done_pulses"}, 64'(pulses), 64'd1);
    chk({tag, ".ready_after"}, {63'd0, rdy_log[6]}, 64'd1);
  endtask

  initial begin
    int dc, np, seen_done;
    vec_t v;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {63'd0, bus.ready}, 64'd1);
    chk("rst.done", {63'd0, bus.done}, 64'd0);
    chk("rst.s", {32'd0, bus.s}, 64'd0);
    chk("rst.cout", {63'd0, bus.cout}, 64'd0);
    chk("rst.ovf", {63'd0, bus.ovf}, 64'd0);
    chk("rst.add_a", {56'd0, bus.add_a}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 0, 0, dc, np);
      check_result($sformatf("vec%0d", i), vecs[i], dc, np);
      chk($sformatf("vec%0d.busy", i), {63'd0, rdy_log[1]}, 64'd0);
      chk($sformatf("vec%0d.add_a_idle", i), {56'd0, adda_log[6]}, 64'd0);
    end

    // Word ordering and carry chaining seen on the adder port.
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 0, 0, dc, np);
    chk("chain.add_cin0", {63'd0, cin_log[1]}, 64'd1);
    chk("chain.add_cin1", {63'd0, cin_log[2]}, 64'd0);
    chk("chain.add_cin2", {63'd0, cin_log[3]}, 64'd0);
    chk("chain.add_cin3", {63'd0, cin_log[4]}, 64'd0);
    chk("chain.add_a0", {56'd0, adda_log[1]}, 64'h78);
    chk("chain.add_a3", {56'd0, adda_log[4]}, 64'h12);
    chk("chain.add_cin_idle", {63'd0, cin_log[6]}, 64'd0);

    // Start pulses during RUN (with changed operand) and during DONE are ignored.
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 2, 5, 0, dc, np);
    check_result("ignore_start", vecs[1], dc, np);

    // Abort on the last word: no done, ready next cycle, cout/ovf kept.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0, 4, dc, np);
    chk("abort.pulses", 64'(np), 64'd0);
    chk("abort.ready_next", {63'd0, rdy_log[5]}, 64'd1);
    chk("abort.cout_kept", {63'd0, bus.cout}, 64'd0);
    chk("abort.ovf_kept", {63'd0, bus.ovf}, 64'd0);
    run_op(vecs[3].a, vecs[3].b, vecs[3].cin, 0, 0, 0, dc, np);
    check_result("after_abort", vecs[3], dc, np);

    // Reset asserted during RUN word 2 clears results immediately.
    run_op(vecs[4].a, vecs[4].b, vecs[4].cin, 0, 0, 0, dc, np);
    @(negedge clk);
    bus.a = 32'h0F0F_0F0F; bus.b = 32'h0101_0101; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.ready", {63'd0, bus.ready}, 64'd1);
    chk("midrst.s", {32'd0, bus.s}, 64'd0);
    chk("midrst.cout", {63'd0, bus.cout}, 64'd0);
    chk("midrst.done", {63'd0, bus.done}, 64'd0);
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    chk("midrst.no_done", 64'(seen_done), 64'd0);
    chk("midrst.s_held", {32'd0, bus.s}, 64'd0);
    run_op(vecs[2].a, vecs[2].b, vecs[2].cin, 0, 0, 0, dc, np);
    check_result("after_rst", vecs[2], dc, np);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
